evu_event_sched: RTL and testbench

EVU_EVENT_SCHED -- requirements
Module: evu_event_sched

---
 rtl/evu_event_sched.sv | 142 ++++++++++++++
 tb/tb_evu_event_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/evu_event_sched.sv
// Event scheduler: per-line saturating event counters, drained one line at a time
// through a round-robin arbiter into a single valid/ready output record.
module evu_event_sched #(
  parameter int NUM_EVT = 5,
  parameter int CNT_W   = 8,
  parameter int INFO_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       flush_i,
  input  logic [NUM_EVT-1:0]         evt_i,
  input  logic [INFO_W-1:0]          info_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(NUM_EVT)-1:0] out_id_o,
  output logic [CNT_W-1:0]           out_count_o,
  output logic [INFO_W-1:0]          out_info_o,
  output logic [NUM_EVT-1:0]         overflow_o
);

  localparam int                ID_W     = $clog2(NUM_EVT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ID_W-1:0]   LAST_RST = ID_W'(NUM_EVT - 1);
  localparam logic [0:0]        S_EMPTY  = 1'b0;
  localparam logic [0:0]        S_FULL   = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q   [NUM_EVT];
  logic [CNT_W-1:0]   cnt_d   [NUM_EVT];
  logic [INFO_W-1:0]  linfo_q [NUM_EVT];
  logic [INFO_W-1:0]  linfo_d [NUM_EVT];
  logic [NUM_EVT-1:0] ovf_q, ovf_d;
  logic [NUM_EVT-1:0] pend, acc;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INFO_W-1:0]  info_q, info_d;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_vld;
  logic               slot_open;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EVT; gi++) begin : g_line
      assign pend[gi] = (cnt_q[gi] != '0);
      assign acc[gi]  = enable_i & evt_i[gi];
    end
  endgenerate

  assign slot_open = (state_q == S_EMPTY) || out_ready_i;

  // Scan from last_grant+1 upward; descending loop lets the nearest pending line win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_EVT; k >= 1; k--) begin
      if (pend[(int'(last_q) + k) % NUM_EVT]) begin
        gnt_vld = slot_open;
        gnt_idx = ID_W'((int'(last_q) + k) % NUM_EVT);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    count_d = count_q;
    info_d  = info_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < NUM_EVT; i++) begin
      cnt_d[i]   = cnt_q[i];
      linfo_d[i] = linfo_q[i];
    end
    if (flush_i) begin
      state_d = S_EMPTY;
      last_d  = LAST_RST;
      id_d    = '0;
      count_d = '0;
      info_d  = '0;
      ovf_d   = '0;
      for (int i = 0; i < NUM_EVT; i++) begin
        cnt_d[i]   = '0;
        linfo_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_EVT; i++) begin
        if (acc[i]) linfo_d[i] = info_i;
        // A granted line restarts from the event arriving in the same cycle, if any.
        if (gnt_vld && (gnt_idx == ID_W'(i))) begin
          cnt_d[i] = acc[i] ? CNT_W'(1) : '0;
        end else if (acc[i]) begin
          if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (gnt_vld) begin
        state_d = S_FULL;
        id_d    = gnt_idx;
        count_d = cnt_q[gnt_idx];
        info_d  = linfo_q[gnt_idx];
        last_d  = gnt_idx;
      end else if ((state_q == S_FULL) && out_ready_i) begin
        state_d = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      last_q  <= LAST_RST;
      id_q    <= '0;
      count_q <= '0;
      info_q  <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < NUM_EVT; i++) begin
        cnt_q[i]   <= '0;
        linfo_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      count_q <= count_d;
      info_q  <= info_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_EVT; i++) begin
        cnt_q[i]   <= cnt_d[i];
        linfo_q[i] <= linfo_d[i];
      end
    end
  end

  assign out_valid_o = (state_q == S_FULL);
  assign out_id_o    = id_q;
  assign out_count_o = count_q;
  assign out_info_o  = info_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_evu_event_sched.sv
// Scoreboard bench for evu_event_sched: directed stimulus pushes expected records,
// a negedge monitor pops and compares each accepted output record.
module tb_evu_event_sched;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       flush;
  logic [4:0] evt;
  logic [3:0] info;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_id;
  logic [7:0] out_count;
  logic [3:0] out_info;
  logic [4:0] overflow;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] cnt;
    logic [3:0] info;
  } rec_t;

  rec_t exp_q[$];
  int   tests;
  int   fails;
  int   ncyc;

  evu_event_sched #(.NUM_EVT(5), .CNT_W(8), .INFO_W(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .flush_i     (flush),
    .evt_i       (evt),
    .info_i      (info),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_id_o    (out_id),
    .out_count_o (out_count),
    .out_info_o  (out_info),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted record must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rec_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_record: got id=%0d count=%0d info=%h, none expected",
                 out_id, out_count, out_info);
      end else begin
        e = exp_q.pop_front();
        if (out_id !== e.id || out_count !== e.cnt || out_info !== e.info) begin
          fails++;
          $display("FAIL record: got id=%0d count=%0d info=%h, expected id=%0d count=%0d info=%h",
                   out_id, out_count, out_info, e.id, e.cnt, e.info);
        end else begin
          $display("[TB] record id=%0d count=%0d info=%h ok", out_id, out_count, out_info);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end else begin
      $display("[TB] %s = %0h ok", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] id, input logic [7:0] cnt, input logic [3:0] inf);
    rec_t r;
    r.id   = id;
    r.cnt  = cnt;
    r.info = inf;
    exp_q.push_back(r);
  endtask

  // Hold ready high until every expected record has been seen (bounded).
  task automatic drain(output int n);
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      step(1);
      n++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d records still expected", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; evt = '0; info = '0; out_ready = 1'b0;
    tests = 0; fails = 0;
    step(2);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_id", 32'(out_id), 32'd0);
    check("reset_count", 32'(out_count), 32'd0);
    check("reset_info", 32'(out_info), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    step(1);

    // Single event, latency 2, handshake in the same cycle it appears
    out_ready = 1'b1;
    evt = 5'b00100; info = 4'hA;
    push(3'd2, 8'd1, 4'hA);
    step(1);
    evt = '0; info = '0;
    check("single_valid_c1", 32'(out_valid), 32'd0);
    step(1);
    check("single_valid_c2", 32'(out_valid), 32'd1);
    step(1);
    check("single_valid_c3", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Round robin: flush sets last_grant=4, line 4 record held while 0,1,4 accumulate
    flush = 1'b1; step(1); flush = 1'b0;
    evt = 5'b10000; info = 4'h3; step(1);
    evt = '0; step(1);
    evt = 5'b10011; step(3);
    evt = '0;
    push(3'd4, 8'd1, 4'h3);
    push(3'd0, 8'd3, 4'h3);
    push(3'd1, 8'd3, 4'h3);
    push(3'd4, 8'd3, 4'h3);
    drain(ncyc);
    check("rr_throughput_cycles", 32'(ncyc), 32'd4);
    check("rr_valid_after_drain", 32'(out_valid), 32'd0);

    // Backpressure: payload stays put while more events land on the granted line
    evt = 5'b00100; info = 4'h1; step(1);
    evt = '0; step(1);
    evt = 5'b00100; info = 4'h5; step(2);
    evt = '0; step(1);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_id", 32'(out_id), 32'd2);
    check("bp_count", 32'(out_count), 32'd1);
    check("bp_info", 32'(out_info), 32'd1);
    push(3'd2, 8'd1, 4'h1);
    push(3'd2, 8'd2, 4'h5);
    drain(ncyc);

    // Saturation: 260 events on line 1 while the first record is held
    evt = 5'b00010; info = 4'h9; step(260);
    evt = '0; step(1);
    check("sat_overflow", 32'(overflow), 32'h02);
    push(3'd1, 8'd1, 4'h9);
    push(3'd1, 8'd255, 4'h9);
    drain(ncyc);
    evt = 5'b01000; info = 4'h0; step(1);
    evt = '0; step(1);
    check("sat_full_before_flush", 32'(out_valid), 32'd1);
    flush = 1'b1; step(1); flush = 1'b0;
    check("flush_overflow", 32'(overflow), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    step(3);
    check("flush_valid_later", 32'(out_valid), 32'd0);

    // Grant/event collision on line 0
    evt = 5'b00001; info = 4'h2; step(1);
    evt = 5'b00001; info = 4'h7; step(1);
    evt = '0; info = '0;
    push(3'd0, 8'd1, 4'h2);
    push(3'd0, 8'd1, 4'h7);
    drain(ncyc);

    // Asynchronous reset while FULL with another line pending
    evt = 5'b01010; info = 4'h4; step(1);
    evt = '0; step(2);
    check("rst_full_before", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_immediate", 32'(out_valid), 32'd0);
    step(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(5);
    check("rst_valid_after_release", 32'(out_valid), 32'd0);
    check("rst_count_after_release", 32'(out_count), 32'd0);
    out_ready = 1'b0;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
